// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM speed command stage
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int SPEED_W_DEFAULT = 3;
    localparam logic [SPEED_W_DEFAULT-1:0] SPEED_MAX = '1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, debounce counter and press pulse for one button
module btn_debounce
    import pwm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level flips and only a rising flip produces a press event
                cnt   <= '0;
                level <= sync_q2;
                press <= sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_speed_ctrl.sv
// rtl/pwm_speed_ctrl.sv - button-driven saturating target with timed soft-start/soft-stop ramp
module pwm_speed_ctrl
    import pwm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int RAMP_CYCLES     = 100000,
    parameter int SPEED_W         = SPEED_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_dn,
    input  logic               btn_stop,
    output logic [SPEED_W-1:0] speed,
    output logic               enable,
    output logic [SPEED_W-1:0] target,
    output logic               busy
);

    localparam int RW = $clog2(RAMP_CYCLES);
    localparam logic [RW-1:0]      RAMP_LAST = RW'(RAMP_CYCLES - 1);
    localparam logic [SPEED_W-1:0] SPD_MAX   = '1;

    logic          up_p;
    logic          dn_p;
    logic          stop_p;
    state_t        state;
    state_t        state_nx;
    logic [RW-1:0] ramp_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_up),
        .press (up_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_dn),
        .press (dn_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_stop),
        .press (stop_p)
    );

    // Stop wins; opposing up/down presses cancel each other
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
        end else if (stop_p) begin
            target <= '0;
        end else if (up_p && !dn_p && target != SPD_MAX) begin
            target <= target + 1'b1;
        end else if (dn_p && !up_p && target != '0) begin
            target <= target - 1'b1;
        end
    end

    always_comb begin
        state_nx = IDLE;
        if (speed < target) begin
            state_nx = UP;
        end else if (speed > target) begin
            state_nx = DOWN;
        end else if (speed != '0) begin
            state_nx = HOLD;
        end
    end

    // Ramp timer restarts on any direction change so every step takes a full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            speed    <= '0;
            ramp_cnt <= '0;
            enable   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state  <= state_nx;
            enable <= (state_nx != IDLE);
            busy   <= (speed != target);
            if (state_nx != state || state_nx == IDLE || state_nx == HOLD) begin
                ramp_cnt <= '0;
            end else if (ramp_cnt == RAMP_LAST) begin
                ramp_cnt <= '0;
                if (state == UP) begin
                    speed <= speed + 1'b1;
                end else begin
                    speed <= speed - 1'b1;
                end
            end else begin
                ramp_cnt <= ramp_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_speed_ctrl.sv
// tb/tb_pwm_speed_ctrl.sv - directed self-checking bench for pwm_speed_ctrl
module tb_pwm_speed_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up;
    logic       btn_dn;
    logic       btn_stop;
    logic [2:0] speed;
    logic       enable;
    logic [2:0] target;
    logic       busy;
    logic [2:0] prev_speed = 3'd0;

    int total = 0;
    int bad   = 0;

    pwm_speed_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .RAMP_CYCLES     (8),
        .SPEED_W         (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .btn_stop (btn_stop),
        .speed    (speed),
        .enable   (enable),
        .target   (target),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // m = {stop, dn, up}
    task automatic press(input logic [2:0] m, input int hi, input int lo);
        {btn_stop, btn_dn, btn_up} = m;
        cyc(hi);
        {btn_stop, btn_dn, btn_up} = 3'b000;
        cyc(lo);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && speed !== prev_speed)
            chk("speed_step", 32'((int'(speed) == int'(prev_speed) + 1) || (int'(speed) == int'(prev_speed) - 1)), 1);
        prev_speed = speed;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        {btn_stop, btn_dn, btn_up} = 3'b000;
        for (int i = 0; i < 8; i++) begin
            {btn_stop, btn_dn, btn_up} = i[2:0];
            cyc(1);
        end
        chk("rst_speed", 32'(speed), 0);
        chk("rst_target", 32'(target), 0);
        chk("rst_enable", 32'(enable), 0);
        chk("rst_busy", 32'(busy), 0);
        {btn_stop, btn_dn, btn_up} = 3'b000;
        cyc(4);
        rst_n = 1'b1;
        cyc(2);

        // Down press from zero
        press(3'b010, 6, 8);
        cyc(4);
        chk("dn_at_zero_target", 32'(target), 0);
        chk("dn_at_zero_enable", 32'(enable), 0);

        // Clean up press, exact latencies
        btn_up = 1'b1;
        cyc(6);
        chk("up_e6_target", 32'(target), 0);
        cyc(1);
        chk("up_e7_target", 32'(target), 1);
        chk("up_e7_enable", 32'(enable), 0);
        cyc(1);
        chk("up_e8_enable", 32'(enable), 1);
        chk("up_e8_busy", 32'(busy), 1);
        cyc(7);
        chk("up_e15_speed", 32'(speed), 0);
        cyc(1);
        chk("up_e16_speed", 32'(speed), 1);
        chk("up_e16_busy", 32'(busy), 1);
        cyc(1);
        chk("up_e17_busy", 32'(busy), 0);
        cyc(3);
        btn_up = 1'b0;
        cyc(10);
        chk("up_single_inc", 32'(target), 1);

        // Bounce then hold, then a 3-cycle glitch
        for (int i = 0; i < 3; i++) begin
            btn_up = 1'b1;
            cyc(2);
            btn_up = 1'b0;
            cyc(2);
        end
        btn_up = 1'b1;
        cyc(12);
        btn_up = 1'b0;
        cyc(10);
        chk("bounce_target", 32'(target), 2);
        press(3'b001, 3, 10);
        chk("glitch_target", 32'(target), 2);
        for (int i = 0; i < 100 && !(speed == 3'd2 && !busy); i++) cyc(1);
        chk("bounce_settle_speed", 32'(speed), 2);

        // Up and down debounced together
        {btn_dn, btn_up} = 2'b11;
        cyc(12);
        chk("updn_target", 32'(target), 2);
        chk("updn_busy", 32'(busy), 0);
        chk("updn_speed", 32'(speed), 2);
        {btn_dn, btn_up} = 2'b00;
        cyc(10);

        // Saturation
        press(3'b100, 6, 10);
        for (int i = 0; i < 200 && enable; i++) cyc(1);
        chk("stop_idle_enable", 32'(enable), 0);
        chk("stop_idle_speed", 32'(speed), 0);
        for (int i = 0; i < 9; i++) press(3'b001, 6, 10);
        chk("sat_target", 32'(target), 7);
        for (int i = 0; i < 300 && !(speed == 3'd7 && !busy); i++) cyc(1);
        chk("sat_speed", 32'(speed), 7);
        press(3'b001, 6, 10);
        chk("sat_extra_target", 32'(target), 7);
        chk("sat_extra_speed", 32'(speed), 7);

        // Stop together with up from full speed
        {btn_stop, btn_up} = 2'b11;
        cyc(6);
        chk("stopup_e6_target", 32'(target), 7);
        cyc(1);
        chk("stopup_e7_target", 32'(target), 0);
        cyc(8);
        chk("stopup_e15_speed", 32'(speed), 7);
        cyc(1);
        chk("stopup_e16_speed", 32'(speed), 6);
        {btn_stop, btn_up} = 2'b00;
        for (int i = 0; i < 200 && enable; i++) cyc(1);
        chk("stopup_end_speed", 32'(speed), 0);

        // Stop during an up ramp at speed 4
        for (int i = 0; i < 4; i++) press(3'b001, 6, 10);
        for (int i = 0; i < 200 && !(speed == 3'd4 && !busy); i++) cyc(1);
        chk("hold4_speed", 32'(speed), 4);
        btn_up = 1'b1;
        cyc(2);
        btn_stop = 1'b1;
        cyc(5);
        chk("ramp_e7_target", 32'(target), 5);
        cyc(2);
        chk("ramp_e9_target", 32'(target), 0);
        cyc(8);
        chk("ramp_e17_speed", 32'(speed), 4);
        cyc(1);
        chk("ramp_e18_speed", 32'(speed), 3);
        cyc(8);
        chk("ramp_e26_speed", 32'(speed), 2);
        cyc(8);
        chk("ramp_e34_speed", 32'(speed), 1);
        cyc(7);
        chk("ramp_e41_enable", 32'(enable), 1);
        cyc(1);
        chk("ramp_e42_speed", 32'(speed), 0);
        chk("ramp_e42_enable", 32'(enable), 1);
        cyc(1);
        chk("ramp_e43_enable", 32'(enable), 0);
        {btn_stop, btn_up} = 2'b00;
        cyc(10);

        // Asynchronous reset in the middle of an up ramp at speed 3
        for (int i = 0; i < 3; i++) press(3'b001, 6, 10);
        btn_up = 1'b1;
        for (int i = 0; i < 60 && !(speed == 3'd3 && target == 3'd4); i++) cyc(1);
        chk("pre_rst_target", 32'(target), 4);
        chk("pre_rst_speed", 32'(speed), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_speed", 32'(speed), 0);
        chk("arst_target", 32'(target), 0);
        chk("arst_enable", 32'(enable), 0);
        chk("arst_busy", 32'(busy), 0);
        btn_up = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
